// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed driver for NUM_DIGITS common-anode 7-segment
// digits sharing one segment bus. Latches a hex word plus decimal-point and
// blank masks, then scans the digits round-robin. Each digit is lit for
// DIGIT_CYCLES clocks. Between digits, every digit is dark for GUARD_CYCLES
// clocks to suppress ghosting. New data reaches the display registers only at
// the frame boundary, so a frame never shows a mix of old and new data.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   enable       1 = scanning, 0 = display dark
//   load         single-cycle strobe capturing value/dp_mask/blank_mask
//   value        packed hex nibbles, digit i = value[4i+3:4i]
//   dp_mask      1 = decimal point lit on digit i
//   blank_mask   1 = digit i forced dark
//   seg          {dp,a,b,c,d,e,f,g}, active-low, registered
//   an           anode selects, active-low, registered
//   frame_tick   one-cycle pulse on the cycle after the frame commit edge
//   busy_pending loaded data is waiting for the next frame commit
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, leading zero digits of the display word are blanked. Digit 0
//   and any digit with its decimal point lit are never blanked by this rule.

module seg7_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned GUARD_CYCLES = 2000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick,
  output logic                    busy_pending
);

  localparam int unsigned VAL_W   = 4 * NUM_DIGITS;
  localparam int unsigned DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_MAX = (DIGIT_CYCLES > GUARD_CYCLES) ? DIGIT_CYCLES : GUARD_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam bit          HAS_GUARD = (GUARD_CYCLES > 0);

  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_GUARD = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  // Active-low {a,b,c,d,e,f,g} pattern for a hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h01;
      4'h1: s = 7'h4F;
      4'h2: s = 7'h12;
      4'h3: s = 7'h06;
      4'h4: s = 7'h4C;
      4'h5: s = 7'h24;
      4'h6: s = 7'h20;
      4'h7: s = 7'h0F;
      4'h8: s = 7'h00;
      4'h9: s = 7'h04;
      4'hA: s = 7'h08;
      4'hB: s = 7'h60;
      4'hC: s = 7'h31;
      4'hD: s = 7'h42;
      4'hE: s = 7'h30;
      4'hF: s = 7'h38;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the top digit; blank zero digits until the first nonzero or dp digit.
  function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(
    input logic [VAL_W-1:0]      v,
    input logic [NUM_DIGITS-1:0] dp
  );
    logic [NUM_DIGITS-1:0] m;
    logic                  run;
    m   = '0;
    run = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      if (run && (v[4*i +: 4] == 4'h0) && !dp[i]) begin
        m[i] = 1'b1;
      end else begin
        run = 1'b0;
      end
    end
    return m;
  endfunction
`endif

  // Scan sequencer state.
  state_e           state_q, state_d;
  logic [DIG_W-1:0] digit_q, digit_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             wrap_c;

  // Pending (loaded) and display (committed) data.
  logic [VAL_W-1:0]      pend_val_q,   pend_val_d;
  logic [NUM_DIGITS-1:0] pend_dp_q,    pend_dp_d;
  logic [NUM_DIGITS-1:0] pend_blank_q, pend_blank_d;
  logic [VAL_W-1:0]      disp_val_q,   disp_val_d;
  logic [NUM_DIGITS-1:0] disp_dp_q,    disp_dp_d;
  logic [NUM_DIGITS-1:0] disp_blank_q, disp_blank_d;
  logic                  busy_q,       busy_d;

  // Registered outputs.
  logic [7:0]            seg_q,  seg_d;
  logic [NUM_DIGITS-1:0] an_q,   an_d;
  logic                  tick_q, tick_d;

  logic [NUM_DIGITS-1:0] blank_eff_c;
  logic [3:0]            nib_c;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      digit_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; wrap_c marks the edge where the digit index returns to 0.
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    cnt_d   = cnt_q;
    wrap_c  = 1'b0;
    if (!enable) begin
      state_d = ST_OFF;
      digit_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = HAS_GUARD ? ST_GUARD : ST_SHOW;
          digit_d = '0;
          cnt_d   = '0;
        end
        ST_GUARD: begin
          if (cnt_q == GUARD_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_SHOW: begin
          if (cnt_q == DIGIT_LAST) begin
            state_d = HAS_GUARD ? ST_GUARD : ST_SHOW;
            cnt_d   = '0;
            if (digit_q == DIG_LAST) begin
              digit_d = '0;
              wrap_c  = 1'b1;
            end else begin
              digit_d = digit_q + DIG_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_OFF;
          digit_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Data commit and output decode, all computed from next-state so the
  // registered pins move on the same edge as the sequencer.
  always_comb begin
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    busy_d       = busy_q;
    tick_d       = 1'b0;
    seg_d        = 8'hFF;
    an_d         = '1;

    if (state_q == ST_OFF) begin
      // Nothing is on screen, so a load can go straight to the display.
      if (load) begin
        pend_val_d   = value;
        pend_dp_d    = dp_mask;
        pend_blank_d = blank_mask;
        disp_val_d   = value;
        disp_dp_d    = dp_mask;
        disp_blank_d = blank_mask;
        busy_d       = 1'b0;
      end
    end else begin
      if (load) begin
        pend_val_d   = value;
        pend_dp_d    = dp_mask;
        pend_blank_d = blank_mask;
        busy_d       = 1'b1;
      end
      if (wrap_c) begin
        // A load on the commit edge bypasses the pending registers.
        disp_val_d   = load ? value      : pend_val_q;
        disp_dp_d    = load ? dp_mask    : pend_dp_q;
        disp_blank_d = load ? blank_mask : pend_blank_q;
        busy_d       = 1'b0;
        tick_d       = 1'b1;
      end
    end

`ifdef LEADING_ZERO_BLANK_EN
    blank_eff_c = disp_blank_d | lead_zero_mask(disp_val_d, disp_dp_d);
`else
    blank_eff_c = disp_blank_d;
`endif

    nib_c = disp_val_d[{digit_d, 2'b00} +: 4];
    if ((state_d == ST_SHOW) && !blank_eff_c[digit_d]) begin
      an_d[digit_d] = 1'b0;
      seg_d         = {~disp_dp_d[digit_d], hex_to_seg(nib_c)};
    end
  end

  // Data and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      busy_q       <= 1'b0;
      tick_q       <= 1'b0;
      seg_q        <= 8'hFF;
      an_q         <= '1;
    end else begin
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      busy_q       <= busy_d;
      tick_q       <= tick_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg          = seg_q;
  assign an           = an_q;
  assign frame_tick   = tick_q;
  assign busy_pending = busy_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with NUM_DIGITS=4, DIGIT_CYCLES=4,
// GUARD_CYCLES=1. Each scan slot is one dark guard cycle followed by four lit
// cycles. Expected segment codes are hand-computed from the hex table.

module tb_seg7_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic [3:0]  blank_mask;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;
  logic        busy_pending;

  int n_checks = 0;
  int n_errors = 0;

  seg7_scan_ctrl #(
    .NUM_DIGITS  (4),
    .DIGIT_CYCLES(4),
    .GUARD_CYCLES(1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .load        (load),
    .value       (value),
    .dp_mask     (dp_mask),
    .blank_mask  (blank_mask),
    .seg         (seg),
    .an          (an),
    .frame_tick  (frame_tick),
    .busy_pending(busy_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One scan slot: a dark guard cycle (with frame_tick expectation), then
  // four lit cycles. If ld is set, load is raised after the second lit cycle.
  task automatic run_slot(input int d, input logic [3:0] an_exp,
                          input logic [7:0] seg_exp, input logic tick_exp,
                          input bit ld);
    step();
    load = 1'b0;
    check($sformatf("d%0d_guard_an", d),   32'(an),         32'hF);
    check($sformatf("d%0d_guard_seg", d),  32'(seg),        32'hFF);
    check($sformatf("d%0d_guard_tick", d), 32'(frame_tick), 32'(tick_exp));
    for (int k = 0; k < 4; k++) begin
      step();
      load = 1'b0;
      check($sformatf("d%0d_c%0d_an", d, k),   32'(an),         32'(an_exp));
      check($sformatf("d%0d_c%0d_seg", d, k),  32'(seg),        32'(seg_exp));
      check($sformatf("d%0d_c%0d_tick", d, k), 32'(frame_tick), 32'h0);
      if (ld && k == 1) load = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; load = 1'b0;
    value = 16'h0; dp_mask = 4'h0; blank_mask = 4'h0;

    // Reset state
    step(); step();
    check("rst_seg",  32'(seg),          32'hFF);
    check("rst_an",   32'(an),           32'hF);
    check("rst_tick", 32'(frame_tick),   32'h0);
    check("rst_busy", 32'(busy_pending), 32'h0);

    // Load while OFF commits immediately without a tick
    rst = 1'b0;
    value = 16'h12AF; load = 1'b1;
    step();
    load = 1'b0;
    check("off_load_busy", 32'(busy_pending), 32'h0);
    check("off_load_tick", 32'(frame_tick),   32'h0);
    check("off_load_seg",  32'(seg),          32'hFF);

    // First frame after enable: F, A, 2, 1
    enable = 1'b1;
    run_slot(0, 4'hE, 8'hB8, 1'b0, 1'b0);
    run_slot(1, 4'hD, 8'h88, 1'b0, 1'b0);
    run_slot(2, 4'hB, 8'h92, 1'b0, 1'b0);
    run_slot(3, 4'h7, 8'hCF, 1'b0, 1'b0);

    // Load coinciding with the commit edge: dp on digit 2 takes effect now
    dp_mask = 4'b0100; load = 1'b1;
    run_slot(0, 4'hE, 8'hB8, 1'b1, 1'b0);
    check("coincide_busy", 32'(busy_pending), 32'h0);
    value = 16'h0000; dp_mask = 4'b0000;
    run_slot(1, 4'hD, 8'h88, 1'b0, 1'b1);   // mid-frame load of 0000
    check("midload_busy", 32'(busy_pending), 32'h1);
    run_slot(2, 4'hB, 8'h12, 1'b0, 1'b0);   // old data, dp still lit
    run_slot(3, 4'h7, 8'hCF, 1'b0, 1'b0);
    check("midload_busy_end", 32'(busy_pending), 32'h1);

    // Commit of 0000 at the wrap
    run_slot(0, 4'hE, 8'h81, 1'b1, 1'b0);
    check("commit_busy", 32'(busy_pending), 32'h0);
    value = 16'h12AF; blank_mask = 4'b1000;
    run_slot(1, 4'hD, 8'h81, 1'b0, 1'b1);
    run_slot(2, 4'hB, 8'h81, 1'b0, 1'b0);
    run_slot(3, 4'h7, 8'h81, 1'b0, 1'b0);

    // Blank digit 3: slot keeps its full length, dark throughout
    run_slot(0, 4'hE, 8'hB8, 1'b1, 1'b0);
    run_slot(1, 4'hD, 8'h88, 1'b0, 1'b0);
    run_slot(2, 4'hB, 8'h92, 1'b0, 1'b0);
    run_slot(3, 4'hF, 8'hFF, 1'b0, 1'b0);
    run_slot(0, 4'hE, 8'hB8, 1'b1, 1'b0);
    run_slot(1, 4'hD, 8'h88, 1'b0, 1'b0);

    // Drop enable while digit 2 is lit
    step();
    check("pre_drop_guard_an", 32'(an), 32'hF);
    step();
    check("pre_drop_an",  32'(an),  32'hB);
    check("pre_drop_seg", 32'(seg), 32'h92);
    enable = 1'b0;
    step();
    check("drop_seg", 32'(seg), 32'hFF);
    check("drop_an",  32'(an),  32'hF);
    step();
    check("off_hold_an", 32'(an), 32'hF);

    // Re-enable restarts at digit 0 after one guard cycle
    enable = 1'b1;
    run_slot(0, 4'hE, 8'hB8, 1'b0, 1'b0);

    // Mid-frame reset with data pending
    step(); step();
    check("pre_rst_an", 32'(an), 32'hD);
    value = 16'h0050; dp_mask = 4'h0; blank_mask = 4'h0; load = 1'b1;
    step();
    load = 1'b0;
    check("pre_rst_busy", 32'(busy_pending), 32'h1);
    rst = 1'b1; enable = 1'b0;
    step();
    check("midrst_seg",  32'(seg),          32'hFF);
    check("midrst_an",   32'(an),           32'hF);
    check("midrst_busy", 32'(busy_pending), 32'h0);
    check("midrst_tick", 32'(frame_tick),   32'h0);

    // Value 0050: leading-zero behaviour depends on the build option
    rst = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    enable = 1'b1;
    run_slot(0, 4'hE, 8'h81, 1'b0, 1'b0);
    run_slot(1, 4'hD, 8'hA4, 1'b0, 1'b0);
`ifdef LEADING_ZERO_BLANK_EN
    run_slot(2, 4'hF, 8'hFF, 1'b0, 1'b0);
    run_slot(3, 4'hF, 8'hFF, 1'b0, 1'b0);
`else
    run_slot(2, 4'hB, 8'h81, 1'b0, 1'b0);
    run_slot(3, 4'h7, 8'h81, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
